// File: rtl/mem_scan_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_scan_reader_if : start/status, memory read port and bit stream bundle  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface mem_scan_reader_if #(
  parameter int AW   = 3,
  parameter int COLS = 8
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic            start;
  logic            busy;
  logic            done;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [COLS-1:0] rd_data;
  logic            bit_valid;
  logic            bit_ready;
  logic            bit_out;
  logic [AW-1:0]   bit_row;
  logic [CW-1:0]   bit_col;
  logic            bit_last;

  modport master (
    input  start, rd_data, bit_ready,
    output busy, done, rd_en, rd_addr,
    output bit_valid, bit_out, bit_row, bit_col, bit_last
  );

  modport slave (
    output start, rd_data, bit_ready,
    input  busy, done, rd_en, rd_addr,
    input  bit_valid, bit_out, bit_row, bit_col, bit_last
  );
endinterface

`default_nettype wire

// File: rtl/mem_scan_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_scan_reader : fetches a ROWS x COLS bit matrix row by row from a       |
// | 1-cycle-latency read port and streams it LSB-first on valid/ready.         |
// | Option macro TRIANGLE_SCAN_EN: row r is len = min(COLS, r + TRI_OFFSET).   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mem_scan_reader #(
  parameter int ROWS       = 7,
  parameter int COLS       = 8,
  parameter int AW         = 3,
  parameter int TRI_OFFSET = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  mem_scan_reader_if.master bus
);

  localparam int            CW       = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   row_q,   row_d;
  logic [CW-1:0]   col_q,   col_d;
  logic [COLS-1:0] word_q,  word_d;

  logic [CW-1:0]   last_col;
  logic            col_end;
  logic            row_end;
  logic            shifting;

`ifdef TRIANGLE_SCAN_EN
  int tri_len;

  always_comb begin
    tri_len = int'(row_q) + TRI_OFFSET;
    if (tri_len >= COLS) begin
      last_col = CW'(COLS - 1);
    end else begin
      last_col = CW'(tri_len - 1);
    end
  end
`else
  assign last_col = CW'(COLS - 1);
`endif

  assign col_end  = (col_q == last_col);
  assign row_end  = (row_q == LAST_ROW);
  assign shifting = (state_q == S_SHIFT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_REQ;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        word_d  = bus.rd_data;
        col_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (bus.bit_ready) begin
          // The current bit always sits in word_q[0]; shorter rows simply end early.
          if (!col_end) begin
            col_d  = col_q + 1'b1;
            word_d = word_q >> 1;
          end else if (!row_end) begin
            row_d   = row_q + 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.rd_en     = (state_q == S_REQ);
  assign bus.rd_addr   = (state_q == S_REQ) ? row_q : '0;
  assign bus.bit_valid = shifting;
  assign bus.bit_out   = shifting & word_q[0];
  assign bus.bit_row   = shifting ? row_q : '0;
  assign bus.bit_col   = shifting ? col_q : '0;
  assign bus.bit_last  = shifting & row_end & col_end;

endmodule

`default_nettype wire
